// File: rtl/noc_pkg.sv
// Shared NoC arbiter definitions: state encoding and default flit width.
package noc_pkg;

    localparam int unsigned NOC_DW = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StLock0 = ST_LOCK0,
        StLock1 = ST_LOCK1
    } st_e;

    function automatic st_e lock_state(input logic idx);
        return idx ? StLock1 : StLock0;
    endfunction

endpackage

// File: rtl/noc_mux2.sv
// Generic single-bit 2:1 mux cell.
module noc_mux2 (
    input  logic d0,
    input  logic d1,
    input  logic s,
    output logic y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/noc_rr_pick.sv
// Combinational 2-way round-robin pick; prio names the winner when both request.
module noc_rr_pick (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    assign gnt_valid = |req;
    assign gnt_idx   = (req == 2'b11) ? prio : req[1];

endmodule

// File: rtl/noc_arb2.sv
// Two-input packet-locked round-robin arbiter for one NoC output link.
// Optional per-input tail counters are enabled by defining NOC_ARB_STATS_EN.
module noc_arb2
    import noc_pkg::*;
#(
    parameter int unsigned DW = NOC_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in0_valid,
    input  logic          in0_last,
    input  logic [DW-1:0] in0_data,
    output logic          in0_ready,
    input  logic          in1_valid,
    input  logic          in1_last,
    input  logic [DW-1:0] in1_data,
    output logic          in1_ready,
    output logic          out_valid,
    output logic          out_last,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          sel,
`ifdef NOC_ARB_STATS_EN
    output logic [15:0]   pkt_cnt0,
    output logic [15:0]   pkt_cnt1,
`endif
    output logic          busy
);

    st_e  st_q, st_d;
    logic prio_q, prio_d;
    logic cur;
    logic xfer, tail;
    logic idle_gnt_valid, idle_gnt_idx;
    logic sw_gnt_valid, sw_gnt_idx;
    logic [1:0] sw_req;

    assign cur  = (st_q == StLock1);
    assign sel  = cur;
    assign busy = (st_q != StIdle);

    assign out_valid = busy && (cur ? in1_valid : in0_valid);
    assign in0_ready = (st_q == StLock0) && out_ready;
    assign in1_ready = (st_q == StLock1) && out_ready;

    for (genvar i = 0; i < int'(DW); i++) begin : g_data_mux
        noc_mux2 u_mux (
            .d0 (in0_data[i]),
            .d1 (in1_data[i]),
            .s  (sel),
            .y  (out_data[i])
        );
    end

    noc_mux2 u_mux_last (
        .d0 (in0_last),
        .d1 (in1_last),
        .s  (sel),
        .y  (out_last)
    );

    assign xfer = out_valid && out_ready;
    assign tail = xfer && out_last;

    noc_rr_pick u_pick_idle (
        .req       ({in1_valid, in0_valid}),
        .prio      (prio_q),
        .gnt_valid (idle_gnt_valid),
        .gnt_idx   (idle_gnt_idx)
    );

    // Only the other input may take over on a tail; the owner goes back through IDLE.
    assign sw_req = cur ? {1'b0, in0_valid} : {in1_valid, 1'b0};

    noc_rr_pick u_pick_switch (
        .req       (sw_req),
        .prio      (~cur),
        .gnt_valid (sw_gnt_valid),
        .gnt_idx   (sw_gnt_idx)
    );

    always_comb begin
        st_d   = st_q;
        prio_d = prio_q;
        case (st_q)
            StIdle: begin
                if (idle_gnt_valid) begin
                    st_d = lock_state(idle_gnt_idx);
                end
            end
            StLock0, StLock1: begin
                if (tail) begin
                    prio_d = ~cur;
                    st_d   = sw_gnt_valid ? lock_state(sw_gnt_idx) : StIdle;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= StIdle;
            prio_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            prio_q <= prio_d;
        end
    end

`ifdef NOC_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            if (tail && !cur && (cnt0_q != 16'hFFFF)) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if (tail && cur && (cnt1_q != 16'hFFFF)) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_noc_arb2.sv
// Scoreboard bench for noc_arb2: queued sources feed the DUT, a monitor checks every transfer.
module tb_noc_arb2;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in0_valid, in0_last, in0_ready;
    logic [DW-1:0] in0_data;
    logic          in1_valid, in1_last, in1_ready;
    logic [DW-1:0] in1_data;
    logic          out_valid, out_last, out_ready;
    logic [DW-1:0] out_data;
    logic          sel, busy;
`ifdef NOC_ARB_STATS_EN
    logic [15:0]   pkt_cnt0, pkt_cnt1;
`endif

    always #5 clk = ~clk;

    noc_arb2 #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_last  (in0_last),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_last  (in1_last),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
`ifdef NOC_ARB_STATS_EN
        .pkt_cnt0  (pkt_cnt0),
        .pkt_cnt1  (pkt_cnt1),
`endif
        .busy      (busy)
    );

    typedef struct packed {
        logic          src;
        logic          last;
        logic [DW-1:0] data;
    } flit_t;

    flit_t exp_q[$];
    flit_t q0[$];
    flit_t q1[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   gap_exp = 0;
    int   last_xfer = -1;
    logic fire0, fire1;

    function automatic flit_t mk(input logic src, input logic last, input logic [DW-1:0] data);
        flit_t f;
        f.src  = src;
        f.last = last;
        f.data = data;
        return f;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic src_push(input logic src, input logic last, input logic [DW-1:0] data);
        if (src) q1.push_back(mk(src, last, data));
        else     q0.push_back(mk(src, last, data));
    endtask

    task automatic exp_push(input logic src, input logic last, input logic [DW-1:0] data);
        exp_q.push_back(mk(src, last, data));
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic wait_presented(input string name, input logic [DW-1:0] d);
        int n = 0;
        while (!(out_valid && out_data == d) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(out_data), 64'(d));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every accepted flit must match the head of the expected queue.
    initial forever begin
        flit_t f;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_flit: got %0h expected none", out_data);
            end else begin
                f = exp_q.pop_front();
                chk("flit_data", 64'(out_data), 64'(f.data));
                chk("flit_last", 64'(out_last), 64'(f.last));
                chk("flit_sel", 64'(sel), 64'(f.src));
                if (gap_exp != 0 && last_xfer >= 0)
                    chk("flit_gap", 64'(cyc - last_xfer), 64'(gap_exp));
                last_xfer = cyc;
            end
        end
    end

    initial begin
        in0_valid = 1'b0; in0_last = 1'b0; in0_data = '0;
        forever begin
            @(negedge clk);
            fire0 = in0_valid && in0_ready && !rst;
            @(posedge clk);
            #1;
            if (fire0 && !rst && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                in0_valid = 1'b1; in0_last = q0[0].last; in0_data = q0[0].data;
            end else begin
                in0_valid = 1'b0;
            end
        end
    end

    initial begin
        in1_valid = 1'b0; in1_last = 1'b0; in1_data = '0;
        forever begin
            @(negedge clk);
            fire1 = in1_valid && in1_ready && !rst;
            @(posedge clk);
            #1;
            if (fire1 && !rst && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                in1_valid = 1'b1; in1_last = q1[0].last; in1_data = q1[0].data;
            end else begin
                in1_valid = 1'b0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        out_ready = 1'b1;
        #1 rst = 1'b1;

        // Reset values with a request already waiting, then a single-flit packet.
        src_push(1'b0, 1'b1, 32'hA5A5_0001);
        exp_push(1'b0, 1'b1, 32'hA5A5_0001);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in0_ready", 64'(in0_ready), 64'd0);
        chk("rst_in1_ready", 64'(in1_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'h0000_0000_A5A5_0001);
        chk("rst_out_last", 64'(out_last), 64'd1);
        rst = 1'b0;
        @(posedge clk); #2;
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_sel", 64'(sel), 64'd0);
        chk("t1_in0_ready", 64'(in0_ready), 64'd1);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_data", 64'(out_data), 64'h0000_0000_A5A5_0001);
        @(posedge clk); #2;
        chk("t1_idle_busy", 64'(busy), 64'd0);
        chk("t1_idle_in0_ready", 64'(in0_ready), 64'd0);
        drain("t1_drain", 20);

        // prio is now 1: a tie goes to input 1, then input 0 without a bubble.
        @(negedge clk);
        src_push(1'b0, 1'b1, 32'h1000_0000);
        src_push(1'b1, 1'b1, 32'h1100_0000);
        exp_push(1'b1, 1'b1, 32'h1100_0000);
        exp_push(1'b0, 1'b1, 32'h1000_0000);
        drain("t1b_drain", 20);

        // Tie after reset: 3-flit packets alternate, starting at input 0, no gaps.
        do_reset();
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < 3; k++) begin
                src_push(1'b0, k == 2, 32'h2000_0000 | (p << 8) | k);
                src_push(1'b1, k == 2, 32'h2100_0000 | (p << 8) | k);
            end
        end
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < 3; k++) exp_push(1'b0, k == 2, 32'h2000_0000 | (p << 8) | k);
            for (int k = 0; k < 3; k++) exp_push(1'b1, k == 2, 32'h2100_0000 | (p << 8) | k);
        end
        last_xfer = -1;
        gap_exp = 1;
        drain("t2_drain", 100);
        gap_exp = 0;

        // Backpressure on input 1 after flit 2; input 0 waits while valid.
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            src_push(1'b1, k == 3, 32'h3100_0000 | k);
            exp_push(1'b1, k == 3, 32'h3100_0000 | k);
        end
        wait_presented("t3_first", 32'h3100_0000);
        src_push(1'b0, 1'b1, 32'h3000_00EE);
        exp_push(1'b0, 1'b1, 32'h3000_00EE);
        wait_presented("t3_second", 32'h3100_0001);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            chk("t3_sel", 64'(sel), 64'd1);
            chk("t3_hold_data", 64'(out_data), 64'h0000_0000_3100_0002);
            chk("t3_in1_ready", 64'(in1_ready), 64'd0);
            chk("t3_in0_ready", 64'(in0_ready), 64'd0);
        end
        out_ready = 1'b1;
        drain("t3_drain", 30);

        // Reset in the middle of a 4-flit packet from input 0.
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            src_push(1'b0, k == 3, 32'h4000_0000 | k);
            exp_push(1'b0, k == 3, 32'h4000_0000 | k);
        end
        wait_presented("t4_flit2", 32'h4000_0001);
        #2 rst = 1'b1;
        #1;
        chk("t4_out_valid", 64'(out_valid), 64'd0);
        chk("t4_in0_ready", 64'(in0_ready), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_sel", 64'(sel), 64'd0);
        exp_q.delete();
        q0.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        src_push(1'b0, 1'b1, 32'h5000_0000);
        src_push(1'b1, 1'b1, 32'h5100_0000);
        exp_push(1'b0, 1'b1, 32'h5000_0000);
        exp_push(1'b1, 1'b1, 32'h5100_0000);
        drain("t4_drain", 20);

        // Input 0 re-requests after each tail: one flit every 2 cycles.
        @(negedge clk);
        for (int p = 0; p < 5; p++) begin
            src_push(1'b0, 1'b1, 32'h6000_0000 | p);
            exp_push(1'b0, 1'b1, 32'h6000_0000 | p);
        end
        last_xfer = -1;
        gap_exp = 2;
        drain("t5_drain", 40);
        gap_exp = 0;

`ifdef NOC_ARB_STATS_EN
        do_reset();
        chk("stats_rst0", 64'(pkt_cnt0), 64'd0);
        chk("stats_rst1", 64'(pkt_cnt1), 64'd0);
        for (int p = 0; p < 70000; p++) begin
            src_push(1'b0, 1'b1, p);
            exp_push(1'b0, 1'b1, p);
        end
        drain("stats_drain", 150000);
        chk("stats_cnt0", 64'(pkt_cnt0), 64'h0000_0000_0000_FFFF);
        chk("stats_cnt1", 64'(pkt_cnt1), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
